// File: rtl/sm_button_filter_pkg.sv
// Shared constants for the button/switch stable-time filter.
// SM_SIM selects a short board-independent filter time for simulation builds.
package sm_button_filter_pkg;

`ifdef SM_SIM
  localparam int DEFAULT_STABLE_CYCLES = 4;
`else
  // About 1 ms at a 50 MHz board clock.
  localparam int DEFAULT_STABLE_CYCLES = 50000;
`endif

  // Width needed to hold 0 .. stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sm_button_filter_bit.sv
// Single-channel stable-time filter: a new level is accepted after STABLE_CYCLES
// consecutive samples that differ from the current level; one-cycle edge pulses.
module sm_button_filter_bit
  import sm_button_filter_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RESET_VALUE;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (d == q) begin
        // Any sample matching the current level restarts the stability window.
        cnt <= '0;
      end else if (cnt == LAST_CNT) begin
        q    <= d;
        cnt  <= '0;
        rise <= d;
        fall <= ~d;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sm_button_filter.sv
// SIZE independent stable-time filter channels plus a combined edge-event flag.
// The combined flag is named evt because "event" is a reserved word.
module sm_button_filter
  import sm_button_filter_pkg::*;
#(
  parameter int              SIZE          = 1,
  parameter int              STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [SIZE-1:0] RESET_VALUE   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall,
  output logic            evt
);

  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    sm_button_filter_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .d    (d[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign evt = |(rise | fall);

endmodule
